// File: rtl/ham_count_32.sv
// ============================================================================
// Module   : ham_count_32
// Purpose  : ALU result conditioning stage. Registers pass-through results and
//            converts the XOR result of the Hamming select into a bit count,
//            delivered on a valid/ready handshake.
// Options  : HAM_FAST_EN - scan four bits per cycle instead of one.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ham_count_32 #(
    parameter int          WIDTH   = 32,
    parameter logic [3:0]  HAM_SEL = 4'b1111
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [3:0]       in_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ham,
    output logic             busy
);

`ifdef HAM_FAST_EN
    localparam int unsigned C_STEP = 4;
`else
    localparam int unsigned C_STEP = 1;
`endif
    localparam int unsigned C_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     sh_q, sh_d;
    logic [C_CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]     out_data_q, out_data_d;
    logic                 out_ham_q, out_ham_d;

    logic [WIDTH-1:0]     w_sh_shift;
    logic [C_CNT_W-1:0]   w_cnt_sum;

    function automatic logic [C_CNT_W-1:0] step_pop(input logic [C_STEP-1:0] bits);
        logic [C_CNT_W-1:0] sum;
        sum = '0;
        for (int i = 0; i < int'(C_STEP); i++) begin
            sum = sum + C_CNT_W'(bits[i]);
        end
        return sum;
    endfunction

    assign w_sh_shift = sh_q >> C_STEP;
    assign w_cnt_sum  = cnt_q + step_pop(sh_q[C_STEP-1:0]);

    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        out_ham_d  = out_ham_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_sel != HAM_SEL) begin
                        out_data_d = in_data;
                        out_ham_d  = 1'b0;
                        state_d    = DONE;
                    end else if (in_data == '0) begin
                        out_data_d = '0;
                        out_ham_d  = 1'b1;
                        state_d    = DONE;
                    end else begin
                        sh_d      = in_data;
                        cnt_d     = '0;
                        out_ham_d = 1'b1;
                        state_d   = COUNT;
                    end
                end
            end
            COUNT: begin
                sh_d  = w_sh_shift;
                cnt_d = w_cnt_sum;
                // Stop as soon as no set bits remain above the scan point.
                if (w_sh_shift == '0) begin
                    out_data_d = WIDTH'(w_cnt_sum);
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sh_q       <= '0;
            cnt_q      <= '0;
            out_data_q <= '0;
            out_ham_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
            out_ham_q  <= out_ham_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = out_data_q;
    assign out_ham   = out_ham_q;

endmodule

`default_nettype wire

// File: tb/tb_ham_count_32.sv
// ============================================================================
// Module   : tb_ham_count_32
// Purpose  : Scoreboard bench for ham_count_32 with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ham_count_32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [3:0]  in_sel = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_ham;
    logic        busy;

    ham_count_32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ham   (out_ham),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        h;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;
    int   last_acc = -100;
    bit   seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", nm, act, expv, cyc);
    endtask

    // Monitor: compares every valid cycle against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_valid", {31'b0, out_valid}, 32'd0);
            end else begin
                chk("out_data", out_data, q[0].d);
                chk("out_ham", {31'b0, out_ham}, {31'b0, q[0].h});
                chk("in_ready_low", {31'b0, in_ready}, 32'd0);
                if (!seen) begin
                    seen = 1'b1;
                    chk("latency", 32'(cyc - q[0].acc + 1), 32'(q[0].lat));
                end
                if (out_ready) begin
                    void'(q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic issue(input logic [31:0] d, input logic [3:0] s,
                         input logic [31:0] ed, input logic eh, input int el);
        exp_t e;
        bit   got;
        got = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_sel   = s;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e.d = ed; e.h = eh; e.lat = el; e.acc = cyc + 1;
                q.push_back(e);
                chk("accept_gap", {31'b0, (e.acc - last_acc) >= 2}, 32'd1);
                last_acc = e.acc;
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
        end
        if (!ok) chk("drain_timeout", 32'd0, 32'd1);
        #1;
    endtask

`ifdef HAM_FAST_EN
    localparam int L_FULL = 9;
    localparam int L_B    = 2;
    localparam int L_F0   = 3;
`else
    localparam int L_FULL = 33;
    localparam int L_B    = 5;
    localparam int L_F0   = 9;
`endif

    initial begin
        #12;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_ham", {31'b0, out_ham}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;

        issue(32'h0000_0000, 4'hF, 32'd0, 1'b1, 1);
        in_valid = 1'b0;
        drain();
        issue(32'hFFFF_FFFF, 4'hF, 32'd32, 1'b1, L_FULL);
        in_valid = 1'b0;
        drain();
        issue(32'h0000_000B, 4'hF, 32'd3, 1'b1, L_B);
        in_valid = 1'b0;
        drain();

        // Backpressure on a pass-through result.
        out_ready = 1'b0;
        issue(32'h1234_5678, 4'h0, 32'h1234_5678, 1'b0, 1);
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // Back-to-back with in_valid held high.
        issue(32'hDEAD_BEEF, 4'h3, 32'hDEAD_BEEF, 1'b0, 1);
        issue(32'h0000_00F0, 4'hF, 32'd4, 1'b1, L_F0);
        issue(32'h0000_0001, 4'h3, 32'h0000_0001, 1'b0, 1);
        issue(32'h0000_000B, 4'hF, 32'd3, 1'b1, L_B);
        in_valid = 1'b0;
        drain();

        // Reset in the middle of a count.
        issue(32'hFFFF_FFFF, 4'hF, 32'd32, 1'b1, L_FULL);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("pre_rst_busy", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_out_data", out_data, 32'd0);
        chk("mid_rst_out_ham", {31'b0, out_ham}, 32'd0);
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        q.delete();
        seen = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("post_rst_idle", {31'b0, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
